// File: rtl/axi_common_types_pkg.sv
// rtl/axi_common_types_pkg.sv - shared AXI widths, burst/resp encodings and FSM state types
package axi_common_types_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_LEN_WIDTH  = 8;
  localparam int AXI_SIZE_WIDTH = 3;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - combinational next-beat address and decode-window check
module axi_burst_addr_gen
  import axi_common_types_pkg::*;
#(
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR   = 32'h5000_0000,
  parameter int                        DEPTH_WORDS = 256
) (
  input  logic [AXI_ADDR_WIDTH:0]   addr,
  input  logic [AXI_SIZE_WIDTH-1:0] size,
  input  logic [AXI_LEN_WIDTH-1:0]  len,
  input  logic [1:0]                burst,
  output logic [AXI_ADDR_WIDTH:0]   next_addr,
  output logic                      in_window
);

  localparam int AW1 = AXI_ADDR_WIDTH + 1;
  localparam logic [AXI_ADDR_WIDTH:0] BASE_X = {1'b0, BASE_ADDR};
  localparam logic [AXI_ADDR_WIDTH:0] SPAN   = AW1'(DEPTH_WORDS * AXI_STRB_WIDTH);

  logic [AXI_ADDR_WIDTH:0] step;
  logic [AXI_ADDR_WIDTH:0] wrap_bytes;
  logic [AXI_ADDR_WIDTH:0] boundary;
  logic [AXI_ADDR_WIDTH:0] incr_addr;

  // Extra top bit lets an address that runs off the 32-bit space fall out of the window instead of wrapping.
  always_comb begin
    step       = AW1'(1) << size;
    wrap_bytes = AW1'({1'b0, len} + 9'd1) << size;
    boundary   = addr & ~(wrap_bytes - AW1'(1));
    incr_addr  = addr + step;
    next_addr  = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (incr_addr >= boundary + wrap_bytes) ? boundary : incr_addr;
      default:     next_addr = incr_addr;
    endcase
    in_window = (addr >= BASE_X) && (addr < BASE_X + SPAN);
  end

endmodule

// File: rtl/axi_slave_mem_responder.sv
// rtl/axi_slave_mem_responder.sv - AXI4 slave byte-strobe RAM with independent write/read FSMs
module axi_slave_mem_responder
  import axi_common_types_pkg::*;
#(
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR   = 32'h5000_0000,
  parameter int                        DEPTH_WORDS = 256,
  parameter int                        ID_W        = AXI_ID_WIDTH
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [ID_W-1:0]           S5_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0] S5_AWADDR,
  input  logic [AXI_LEN_WIDTH-1:0]  S5_AWLEN,
  input  logic [AXI_SIZE_WIDTH-1:0] S5_AWSIZE,
  input  logic [1:0]                S5_AWBURST,
  input  logic                      S5_AWVALID,
  output logic                      S5_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0] S5_WDATA,
  input  logic [AXI_STRB_WIDTH-1:0] S5_WSTRB,
  input  logic                      S5_WLAST,
  input  logic                      S5_WVALID,
  output logic                      S5_WREADY,
  output logic [ID_W-1:0]           S5_BID,
  output logic [1:0]                S5_BRESP,
  output logic                      S5_BVALID,
  input  logic                      S5_BREADY,
  input  logic [ID_W-1:0]           S5_ARID,
  input  logic [AXI_ADDR_WIDTH-1:0] S5_ARADDR,
  input  logic [AXI_LEN_WIDTH-1:0]  S5_ARLEN,
  input  logic [AXI_SIZE_WIDTH-1:0] S5_ARSIZE,
  input  logic [1:0]                S5_ARBURST,
  input  logic                      S5_ARVALID,
  output logic                      S5_ARREADY,
  output logic [ID_W-1:0]           S5_RID,
  output logic [AXI_DATA_WIDTH-1:0] S5_RDATA,
  output logic [1:0]                S5_RRESP,
  output logic                      S5_RLAST,
  output logic                      S5_RVALID,
  input  logic                      S5_RREADY
);

  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int BYTE_SH = $clog2(AXI_STRB_WIDTH);
  localparam logic [AXI_ADDR_WIDTH:0] BASE_X = {1'b0, BASE_ADDR};

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH:0] a);
    return IDX_W'((a - BASE_X) >> BYTE_SH);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // ---------------- write side ----------------
  w_state_e                  w_state, w_state_next;
  logic [AXI_ADDR_WIDTH:0]   w_addr, w_next;
  logic [ID_W-1:0]           w_id;
  logic [AXI_LEN_WIDTH-1:0]  w_len, w_beat;
  logic [AXI_SIZE_WIDTH-1:0] w_size;
  logic [1:0]                w_burst;
  logic                      w_err, w_in_win;
  logic                      aw_hs, w_hs, w_last_beat, w_beat_err, w_done;

  axi_burst_addr_gen #(.BASE_ADDR(BASE_ADDR), .DEPTH_WORDS(DEPTH_WORDS)) u_wgen (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst),
    .next_addr(w_next), .in_window(w_in_win)
  );

  assign aw_hs       = S5_AWVALID & S5_AWREADY;
  assign w_hs        = S5_WVALID & S5_WREADY;
  assign w_last_beat = (w_beat == w_len);
  assign w_beat_err  = !w_in_win || (w_burst == BURST_RSVD) || (S5_WLAST != w_last_beat);
  assign w_done      = S5_WLAST || w_last_beat;

  // Write FSM state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_next;
  end

  // Write FSM transitions and handshake outputs.
  always_comb begin
    w_state_next = w_state;
    S5_AWREADY   = 1'b0;
    S5_WREADY    = 1'b0;
    S5_BVALID    = 1'b0;
    S5_BID       = '0;
    S5_BRESP     = RESP_OKAY;
    case (w_state)
      W_IDLE: begin
        S5_AWREADY = 1'b1;
        if (S5_AWVALID) w_state_next = W_DATA;
      end
      W_DATA: begin
        S5_WREADY = 1'b1;
        if (S5_WVALID && w_done) w_state_next = W_RESP;
      end
      W_RESP: begin
        S5_BVALID = 1'b1;
        S5_BID    = w_id;
        S5_BRESP  = w_err ? RESP_SLVERR : RESP_OKAY;
        if (S5_BREADY) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // Latch the AW payload, then advance address/beat and accumulate the error flag per W beat.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_addr  <= '0;
      w_id    <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_addr  <= {1'b0, S5_AWADDR};
      w_id    <= S5_AWID;
      w_len   <= S5_AWLEN;
      w_size  <= S5_AWSIZE;
      w_burst <= S5_AWBURST;
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr  <= w_next;
      w_beat  <= w_beat + 8'd1;
      w_err   <= w_err | w_beat_err;
    end
  end

  // Byte-strobed RAM write; out-of-window beats and beats caught by reset write nothing.
  always_ff @(posedge ACLK) begin
    if (!ARESET && w_hs && w_in_win) begin
      for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
        if (S5_WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= S5_WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read side ----------------
  r_state_e                  r_state, r_state_next;
  logic [AXI_ADDR_WIDTH:0]   r_addr, r_next, r_rd_addr;
  logic [ID_W-1:0]           r_id;
  logic [AXI_LEN_WIDTH-1:0]  r_len, r_beat;
  logic [AXI_SIZE_WIDTH-1:0] r_size;
  logic [1:0]                r_burst;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic                      r_in_win, ar_hs, r_hs;

  axi_burst_addr_gen #(.BASE_ADDR(BASE_ADDR), .DEPTH_WORDS(DEPTH_WORDS)) u_rgen (
    .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst),
    .next_addr(r_next), .in_window(r_in_win)
  );

  assign ar_hs     = S5_ARVALID & S5_ARREADY;
  assign r_hs      = S5_RVALID & S5_RREADY;
  assign r_rd_addr = (r_state == R_IDLE) ? {1'b0, S5_ARADDR} : r_next;

  // Read FSM state register.
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_next;
  end

  // Read FSM transitions; payload is a pure function of registered beat state so it holds under backpressure.
  always_comb begin
    r_state_next = r_state;
    S5_ARREADY   = 1'b0;
    S5_RVALID    = 1'b0;
    S5_RLAST     = 1'b0;
    S5_RID       = '0;
    S5_RDATA     = '0;
    S5_RRESP     = RESP_OKAY;
    case (r_state)
      R_IDLE: begin
        S5_ARREADY = 1'b1;
        if (S5_ARVALID) r_state_next = R_DATA;
      end
      R_DATA: begin
        S5_RVALID = 1'b1;
        S5_RID    = r_id;
        S5_RLAST  = (r_beat == r_len);
        S5_RDATA  = r_in_win ? rdata_q : '0;
        S5_RRESP  = (!r_in_win || r_burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
        if (S5_RREADY && S5_RLAST) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Latch AR, step per accepted beat, and fetch the next beat's word on the same edge.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_addr  <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      rdata_q <= '0;
    end else begin
      if (ar_hs) begin
        r_addr  <= {1'b0, S5_ARADDR};
        r_id    <= S5_ARID;
        r_len   <= S5_ARLEN;
        r_size  <= S5_ARSIZE;
        r_burst <= S5_ARBURST;
        r_beat  <= '0;
      end else if (r_hs) begin
        r_addr  <= r_next;
        r_beat  <= r_beat + 8'd1;
      end
      if (ar_hs || (r_hs && !S5_RLAST)) rdata_q <= mem[word_idx(r_rd_addr)];
    end
  end

endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// tb/tb_axi_slave_mem_responder.sv - self-checking bench with a word-array reference model
module tb_axi_slave_mem_responder;

  localparam longint BASE  = 64'h5000_0000;
  localparam int     DEPTH = 256;
  localparam int     TMO   = 50;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S5_AWID, S5_ARID, S5_BID, S5_RID;
  logic [31:0] S5_AWADDR, S5_ARADDR, S5_WDATA, S5_RDATA;
  logic [7:0]  S5_AWLEN, S5_ARLEN;
  logic [2:0]  S5_AWSIZE, S5_ARSIZE;
  logic [1:0]  S5_AWBURST, S5_ARBURST, S5_BRESP, S5_RRESP;
  logic [3:0]  S5_WSTRB;
  logic        S5_AWVALID, S5_AWREADY, S5_WLAST, S5_WVALID, S5_WREADY;
  logic        S5_BVALID, S5_BREADY, S5_ARVALID, S5_ARREADY;
  logic        S5_RLAST, S5_RVALID, S5_RREADY;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mw [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  axi_slave_mem_responder #(.BASE_ADDR(32'h5000_0000), .DEPTH_WORDS(DEPTH), .ID_W(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S5_AWID(S5_AWID), .S5_AWADDR(S5_AWADDR), .S5_AWLEN(S5_AWLEN), .S5_AWSIZE(S5_AWSIZE),
    .S5_AWBURST(S5_AWBURST), .S5_AWVALID(S5_AWVALID), .S5_AWREADY(S5_AWREADY),
    .S5_WDATA(S5_WDATA), .S5_WSTRB(S5_WSTRB), .S5_WLAST(S5_WLAST),
    .S5_WVALID(S5_WVALID), .S5_WREADY(S5_WREADY),
    .S5_BID(S5_BID), .S5_BRESP(S5_BRESP), .S5_BVALID(S5_BVALID), .S5_BREADY(S5_BREADY),
    .S5_ARID(S5_ARID), .S5_ARADDR(S5_ARADDR), .S5_ARLEN(S5_ARLEN), .S5_ARSIZE(S5_ARSIZE),
    .S5_ARBURST(S5_ARBURST), .S5_ARVALID(S5_ARVALID), .S5_ARREADY(S5_ARREADY),
    .S5_RID(S5_RID), .S5_RDATA(S5_RDATA), .S5_RRESP(S5_RRESP), .S5_RLAST(S5_RLAST),
    .S5_RVALID(S5_RVALID), .S5_RREADY(S5_RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address of beat i from the burst rules, in unbounded integer arithmetic.
  function automatic longint beat_addr(longint start, int size, int len, int burst, int i);
    longint step, total, bnd;
    step = longint'(1) << size;
    if (burst == 0) return start;
    if (burst == 2) begin
      total = longint'(len + 1) * step;
      bnd   = (start / total) * total;
      return bnd + ((start - bnd + longint'(i) * step) % total);
    end
    return start + longint'(i) * step;
  endfunction

  function automatic bit in_win(longint a);
    return (a >= BASE) && (a < BASE + DEPTH * 4);
  endfunction

  task automatic wr(input logic [3:0] id, input longint addr, input int len, input int size,
                    input int burst, input int early);
    int nb, t;
    bit err;
    longint a;
    int idx;
    nb  = (early >= 0) ? early + 1 : len + 1;
    err = (burst == 3) || (early >= 0 && early != len);
    @(negedge ACLK);
    S5_AWID = id; S5_AWADDR = addr[31:0]; S5_AWLEN = 8'(len); S5_AWSIZE = 3'(size);
    S5_AWBURST = 2'(burst); S5_AWVALID = 1'b1;
    t = 0;
    while (!S5_AWREADY && t < TMO) begin @(negedge ACLK); t++; end
    chk("aw_wait", 64'(t < TMO), 1);
    @(negedge ACLK);
    S5_AWVALID = 1'b0;
    for (int i = 0; i < nb; i++) begin
      S5_WDATA = wd[i]; S5_WSTRB = ws[i]; S5_WLAST = (i == nb - 1); S5_WVALID = 1'b1;
      t = 0;
      while (!S5_WREADY && t < TMO) begin @(negedge ACLK); t++; end
      chk("w_wait", 64'(t < TMO), 1);
      @(negedge ACLK);
      a = beat_addr(addr, size, len, burst, i);
      if (in_win(a)) begin
        idx = int'((a - BASE) >> 2);
        for (int b = 0; b < 4; b++) if (ws[i][b]) mw[idx][8*b +: 8] = wd[i][8*b +: 8];
      end else err = 1'b1;
    end
    S5_WVALID = 1'b0; S5_WLAST = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge ACLK);
    S5_BREADY = 1'b1;
    t = 0;
    while (!S5_BVALID && t < TMO) begin @(negedge ACLK); t++; end
    chk("b_wait", 64'(t < TMO), 1);
    chk("bid", S5_BID, id);
    chk("bresp", S5_BRESP, err ? 2 : 0);
    @(negedge ACLK);
    S5_BREADY = 1'b0;
    chk("awready_after_b", S5_AWREADY, 1);
  endtask

  task automatic rd(input logic [3:0] id, input longint addr, input int len, input int size,
                    input int burst, input int stall_first);
    int t, stall;
    longint a;
    logic [31:0] ed;
    logic [1:0]  er;
    @(negedge ACLK);
    S5_ARID = id; S5_ARADDR = addr[31:0]; S5_ARLEN = 8'(len); S5_ARSIZE = 3'(size);
    S5_ARBURST = 2'(burst); S5_ARVALID = 1'b1;
    t = 0;
    while (!S5_ARREADY && t < TMO) begin @(negedge ACLK); t++; end
    chk("ar_wait", 64'(t < TMO), 1);
    @(negedge ACLK);
    S5_ARVALID = 1'b0;
    chk("rvalid_one_cycle", S5_RVALID, 1);
    for (int i = 0; i <= len; i++) begin
      a  = beat_addr(addr, size, len, burst, i);
      ed = in_win(a) ? mw[int'((a - BASE) >> 2)] : 32'h0;
      er = (!in_win(a) || burst == 3) ? 2'd2 : 2'd0;
      stall = (i == 0) ? stall_first : int'($urandom_range(0, 1));
      S5_RREADY = 1'b0;
      for (int s = 0; s < stall; s++) begin
        chk("rvalid_hold", S5_RVALID, 1);
        chk("rdata_hold", S5_RDATA, ed);
        @(negedge ACLK);
      end
      S5_RREADY = 1'b1;
      chk("rvalid", S5_RVALID, 1);
      chk("rdata", S5_RDATA, ed);
      chk("rresp", S5_RRESP, er);
      chk("rlast", S5_RLAST, i == len);
      chk("rid", S5_RID, id);
      @(negedge ACLK);
    end
    S5_RREADY = 1'b0;
    chk("rvalid_after_last", S5_RVALID, 0);
  endtask

  initial begin
    int burst, len, word;
    ARESET = 1'b1;
    S5_AWID = '0; S5_AWADDR = '0; S5_AWLEN = '0; S5_AWSIZE = '0; S5_AWBURST = '0; S5_AWVALID = 1'b0;
    S5_WDATA = '0; S5_WSTRB = '0; S5_WLAST = 1'b0; S5_WVALID = 1'b0; S5_BREADY = 1'b0;
    S5_ARID = '0; S5_ARADDR = '0; S5_ARLEN = '0; S5_ARSIZE = '0; S5_ARBURST = '0; S5_ARVALID = 1'b0;
    S5_RREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("rst_awready", S5_AWREADY, 1);
    chk("rst_arready", S5_ARREADY, 1);
    chk("rst_wready", S5_WREADY, 0);
    chk("rst_bvalid", S5_BVALID, 0);
    chk("rst_rvalid", S5_RVALID, 0);
    chk("rst_rlast", S5_RLAST, 0);
    chk("rst_bid_bresp", {S5_BID, S5_BRESP}, 0);
    chk("rst_rid_rresp_rdata", {S5_RID, S5_RRESP, S5_RDATA}, 0);
    ARESET = 1'b0;

    // Fill the whole memory so every later read has a known value.
    for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    wr(4'h1, BASE, 255, 2, 1, -1);

    // Single write then read.
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    wr(4'h3, BASE + 'h10, 0, 2, 1, -1);
    chk("single_model", mw[4], 32'hDEADBEEF);
    rd(4'h3, BASE + 'h10, 0, 2, 1, 0);

    // INCR 4 beats, partial strobe on beat 2, read with ARID=A.
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    ws[2] = 4'h3;
    wr(4'h5, BASE + 'h40, 3, 2, 1, -1);
    rd(4'hA, BASE + 'h40, 3, 2, 1, 0);

    // WRAP len=3 from offset 0x38: offsets 0x38, 0x3C, 0x30, 0x34.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA000_0000 + i; ws[i] = 4'hF; end
    wr(4'h6, BASE + 'h38, 3, 2, 2, -1);
    chk("wrap_model_b2", mw['h30 >> 2], 32'hA000_0002);
    rd(4'h6, BASE + 'h38, 3, 2, 2, 0);

    // Top edge of the window: second beat is out of range.
    rd(4'h7, BASE + DEPTH * 4 - 4, 1, 2, 1, 0);
    wd[0] = $urandom; wd[1] = $urandom; ws[0] = 4'hF; ws[1] = 4'hF;
    wr(4'h7, BASE + DEPTH * 4 - 4, 1, 2, 1, -1);

    // End of the 32-bit space must not wrap back into the window.
    rd(4'h8, 64'hFFFF_FFFC, 1, 2, 1, 0);

    // Early WLAST on beat 1 of a len=3 burst.
    wd[0] = $urandom; wd[1] = $urandom; ws[0] = 4'hF; ws[1] = 4'hF;
    wr(4'h9, BASE + 'h100, 3, 2, 1, 1);

    // Reserved burst type with empty strobe.
    ws[0] = 4'h0; ws[1] = 4'h0;
    wr(4'hB, BASE + 'h200, 1, 2, 3, -1);

    // RREADY held low for 5 cycles on the first beat.
    rd(4'hC, BASE + 'h80, 2, 2, 1, 5);

    // Reset during beat 2 of an 8-beat read.
    @(negedge ACLK);
    S5_ARID = 4'hD; S5_ARADDR = 32'(BASE + 'hC0); S5_ARLEN = 8'd7; S5_ARSIZE = 3'd2;
    S5_ARBURST = 2'd1; S5_ARVALID = 1'b1;
    @(negedge ACLK);
    S5_ARVALID = 1'b0; S5_RREADY = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("pre_reset_rvalid", S5_RVALID, 1);
    S5_RREADY = 1'b0; ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    chk("mid_reset_rvalid", S5_RVALID, 0);
    chk("mid_reset_arready", S5_ARREADY, 1);
    rd(4'hE, BASE + 'hC0, 7, 2, 1, 0);
    rd(4'h2, BASE + 'h10, 0, 2, 1, 0);

    // Randomized bursts checked against the model.
    for (int k = 0; k < 16; k++) begin
      burst = int'($urandom_range(0, 2));
      len   = (burst == 2) ? ((1 << $urandom_range(1, 4)) - 1) : int'($urandom_range(0, 15));
      word  = int'($urandom_range(0, DEPTH - 1));
      for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      wr(4'($urandom), BASE + longint'(word) * 4, len, 2, burst, -1);
      rd(4'($urandom), BASE + longint'(word) * 4, len, 2, burst, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
